// File: rtl/sqrt_pkg.sv
// sqrt_pkg: FSM state type and width helpers for the shared square-root engine
package sqrt_pkg;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  function automatic int root_w(input int n);
    return n / 2;
  endfunction
  function automatic int rem_w(input int n);
    return n / 2 + 1;
  endfunction
  function automatic int acc_w(input int n);
    return n / 2 + 2;
  endfunction
endpackage

// File: rtl/sqrt_nr_step.sv
// sqrt_nr_step: one combinational non-restoring square-root iteration
module sqrt_nr_step
  import sqrt_pkg::*;
#(
  parameter int N = 32,
  localparam int RW = root_w(N),
  localparam int AW = acc_w(N)
) (
  input  logic [AW-1:0] i_rem,
  input  logic [RW-1:0] i_q,
  input  logic [1:0]    i_pair,
  output logic [AW-1:0] o_rem,
  output logic [RW-1:0] o_q
);
  logic [AW-1:0] w_sh;
  assign w_sh  = (i_rem << 2) | {{(AW-2){1'b0}}, i_pair};
  assign o_rem = i_rem[AW-1] ? w_sh + {i_q, 2'b11} : w_sh - {i_q, 2'b01};
  assign o_q   = {i_q[RW-2:0], ~o_rem[AW-1]};
endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin arbiter sharing one iterative square-root engine
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter int N   = 32,
  parameter int REQ = 4,
  parameter int IDW = $clog2(REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [REQ-1:0]     i_req_valid,
  input  logic [REQ*N-1:0]   i_req_number,
  output logic [REQ-1:0]     o_req_ready,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [IDW-1:0]     o_resp_id,
  output logic [N/2-1:0]     o_root,
  output logic [N/2:0]       o_remainder
);
  localparam int RW = root_w(N);
  localparam int AW = acc_w(N);
  localparam int IW = $clog2(RW);
  state_t          r_state, w_state_n;
  logic [N-1:0]    r_num, w_opnd;
  logic [AW-1:0]   r_rem, w_rem_n;
  logic [RW-1:0]   r_q, w_q_n;
  logic [IW-1:0]   r_i;
  logic [IDW-1:0]  r_id, r_last, w_gnt_id, w_cand;
  logic [REQ-1:0]  w_gnt_oh;
  logic            w_found;
  logic [1:0]      w_pair;
  logic [RW:0]     w_rem_fix;
  // Round-robin search starting just after the last served requester
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_cand   = '0;
    for (int k = 0; k < REQ; k++) begin
      w_cand = IDW'((int'(r_last) + 1 + k) % REQ);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_gnt_id = w_cand;
      end
    end
    w_gnt_oh = w_found ? REQ'(1) << w_gnt_id : '0;
  end
  // Select the granted requester's operand
  always_comb begin
    w_opnd = '0;
    for (int k = 0; k < REQ; k++)
      if (IDW'(k) == w_gnt_id) w_opnd = i_req_number[k*N +: N];
  end
  assign o_req_ready  = (r_state == IDLE) ? w_gnt_oh : '0;
  assign o_resp_valid = (r_state == DONE);
  assign w_pair       = r_num[{r_i, 1'b0} +: 2];
  assign w_rem_fix    = r_rem[RW:0] + (r_rem[AW-1] ? {r_q, 1'b1} : '0);
  sqrt_nr_step #(.N(N)) u_step (
    .i_rem  (r_rem),
    .i_q    (r_q),
    .i_pair (w_pair),
    .o_rem  (w_rem_n),
    .o_q    (w_q_n)
  );
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = w_found ? ITER : IDLE;
      ITER:    w_state_n = (r_i == '0) ? FIX : ITER;
      FIX:     w_state_n = DONE;
      DONE:    w_state_n = i_resp_ready ? IDLE : DONE;
      default: w_state_n = IDLE;
    endcase
  end
  // Operand capture, iteration registers and registered response fields
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_i         <= '0;
      r_id        <= '0;
      r_last      <= IDW'(REQ - 1);
      o_root      <= '0;
      o_remainder <= '0;
      o_resp_id   <= '0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_num <= w_opnd;
        r_id  <= w_gnt_id;
        r_rem <= '0;
        r_q   <= '0;
        r_i   <= IW'(RW - 1);
      end
      if (r_state == ITER) begin
        r_rem <= w_rem_n;
        r_q   <= w_q_n;
        r_i   <= r_i - 1'b1;
      end
      if (r_state == FIX) begin
        o_root      <= r_q;
        o_remainder <= w_rem_fix;
        o_resp_id   <= r_id;
      end
      if (o_resp_valid && i_resp_ready) r_last <= r_id;
    end
  end
endmodule
